// File: rtl/rv_multicycle_control.sv
// RV32I multi-cycle controller: sequences FETCH/DECODE/EXECUTE/MEM/WB over
// ready-handshaked memories and drives an external register file and ALU.
module rv_multicycle_control #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_PC  = 32'h0000_0100
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                imem_req,
   output logic [XLEN-1:0]     imem_addr,
   input  logic                imem_ready,
   input  logic [31:0]         imem_rdata,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic [XLEN/8-1:0]   dmem_be,
   output logic [XLEN-1:0]     dmem_addr,
   output logic [XLEN-1:0]     dmem_wdata,
   input  logic                dmem_ready,
   input  logic [XLEN-1:0]     dmem_rdata,
   output logic [4:0]          rf_raddr1,
   output logic [4:0]          rf_raddr2,
   input  logic [XLEN-1:0]     rf_rdata1,
   input  logic [XLEN-1:0]     rf_rdata2,
   output logic                rf_we,
   output logic [4:0]          rf_waddr,
   output logic [XLEN-1:0]     rf_wdata,
   output logic [XLEN-1:0]     alu_a,
   output logic [XLEN-1:0]     alu_b,
   output logic [3:0]          alu_op,
   input  logic [XLEN-1:0]     alu_result,
   output logic [XLEN-1:0]     pc,
   output logic                trap,
   output logic                retire
);

   localparam int BW = XLEN / 8;

   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_BR    = 7'b1100011;
   localparam logic [6:0] OPC_LD    = 7'b0000011;
   localparam logic [6:0] OPC_ST    = 7'b0100011;
   localparam logic [6:0] OPC_OPI   = 7'b0010011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;
   localparam logic [3:0] ALU_SLT  = 4'b1001;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   state_t state_q, state_n;

   logic [XLEN-1:0] pc_q, a_q, b_q, res_q, npc_q, ea_q;
   logic [31:0]     ir_q;

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [4:0] rd;
   logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
   logic legal;
   logic [XLEN-1:0] imm;
   logic [3:0]      alu_op_d;

   assign opcode   = ir_q[6:0];
   assign f3       = ir_q[14:12];
   assign f7       = ir_q[31:25];
   assign rd       = ir_q[11:7];
   assign is_lui   = (opcode == OPC_LUI);
   assign is_auipc = (opcode == OPC_AUIPC);
   assign is_jal   = (opcode == OPC_JAL);
   assign is_jalr  = (opcode == OPC_JALR);
   assign is_br    = (opcode == OPC_BR);
   assign is_ld    = (opcode == OPC_LD);
   assign is_st    = (opcode == OPC_ST);
   assign is_opi   = (opcode == OPC_OPI);
   assign is_op    = (opcode == OPC_OP);

   always_comb begin
      legal = 1'b0;
      case (opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
         OPC_JALR: legal = (f3 == 3'b000);
         OPC_BR:   legal = (f3 != 3'b010) && (f3 != 3'b011);
         OPC_LD:   legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                           (f3 == 3'b100) || (f3 == 3'b101);
         OPC_ST:   legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
         OPC_OPI: begin
            if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
            else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            else                   legal = 1'b1;
         end
         OPC_OP:   legal = (f7 == 7'b0000000) ||
                           ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
         default:  legal = 1'b0;
      endcase
   end

   // Every immediate form is sign-extended from IR[31], BLTU/BGEU included.
   always_comb begin
      imm = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
      if (is_st)
         imm = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      else if (is_br)
         imm = {{(XLEN-12){ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      else if (is_lui || is_auipc)
         imm = {{(XLEN-32){ir_q[31]}}, ir_q[31:12], 12'b0};
      else if (is_jal)
         imm = {{(XLEN-20){ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
   end

   always_comb begin
      alu_op_d = ALU_ADD;
      if (is_op || is_opi) begin
         case (f3)
            3'b000:  alu_op_d = (is_op && f7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op_d = ALU_SLL;
            3'b010:  alu_op_d = ALU_SLT;
            3'b011:  alu_op_d = ALU_SLTU;
            3'b100:  alu_op_d = ALU_XOR;
            3'b101:  alu_op_d = f7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op_d = ALU_OR;
            default: alu_op_d = ALU_AND;
         endcase
      end
   end

   logic signed [XLEN-1:0] a_s, b_s;
   logic [XLEN-1:0] ea_sum, pc_imm, pc_4, jalr_tgt;
   logic br_taken, misalign;

   assign a_s      = a_q;
   assign b_s      = b_q;
   assign ea_sum   = a_q + imm;
   assign pc_imm   = pc_q + imm;
   assign pc_4     = pc_q + XLEN'(4);
   assign jalr_tgt = {ea_sum[XLEN-1:1], 1'b0};

   always_comb begin
      case (f3)
         3'b000:  br_taken = (a_q == b_q);
         3'b001:  br_taken = (a_q != b_q);
         3'b100:  br_taken = (a_s <  b_s);
         3'b101:  br_taken = (a_s >= b_s);
         3'b110:  br_taken = (a_q <  b_q);
         default: br_taken = (a_q >= b_q);
      endcase
   end

   always_comb begin
      case (f3[1:0])
         2'b01:   misalign = ea_sum[0];
         2'b10:   misalign = (ea_sum[1:0] != 2'b00);
         default: misalign = 1'b0;
      endcase
   end

   // Store lane steering and load lane extraction both key off the captured EA.
   logic [BW-1:0]   st_be;
   logic [XLEN-1:0] st_wdata, ld_shift, ld_val;

   assign ld_shift = dmem_rdata >> {ea_q[1:0], 3'b000};

   always_comb begin
      case (f3[1:0])
         2'b00: begin
            st_be    = BW'(1) << ea_q[1:0];
            st_wdata = {(XLEN/8){b_q[7:0]}};
         end
         2'b01: begin
            st_be    = BW'(3) << ea_q[1:0];
            st_wdata = {(XLEN/16){b_q[15:0]}};
         end
         default: begin
            st_be    = {BW{1'b1}};
            st_wdata = b_q;
         end
      endcase
   end

   always_comb begin
      case (f3)
         3'b000:  ld_val = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
         3'b001:  ld_val = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
         3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
         3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
         default: ld_val = ld_shift;
      endcase
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_n;
   end

   always_comb begin
      state_n    = state_q;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_be    = '0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      rf_raddr1  = 5'd0;
      rf_raddr2  = 5'd0;
      rf_we      = 1'b0;
      rf_waddr   = 5'd0;
      rf_wdata   = '0;
      alu_a      = '0;
      alu_b      = '0;
      alu_op     = ALU_ADD;
      trap       = 1'b0;
      retire     = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req = rst_n;
            if (imem_ready) state_n = S_DECODE;
         end
         S_DECODE: begin
            rf_raddr1 = ir_q[19:15];
            rf_raddr2 = ir_q[24:20];
            state_n   = legal ? S_EXEC : S_TRAP;
         end
         S_EXEC: begin
            alu_a  = a_q;
            alu_b  = (is_op || is_br) ? b_q : imm;
            alu_op = alu_op_d;
            if (is_jal)
               state_n = pc_imm[1] ? S_TRAP : S_WB;
            else if (is_jalr)
               state_n = jalr_tgt[1] ? S_TRAP : S_WB;
            else if (is_br) begin
               if (br_taken && pc_imm[1]) state_n = S_TRAP;
               else begin
                  retire  = 1'b1;
                  state_n = S_FETCH;
               end
            end
            else if (is_ld || is_st)
               state_n = misalign ? S_TRAP : S_MEM;
            else
               state_n = S_WB;
         end
         S_MEM: begin
            dmem_req  = 1'b1;
            dmem_we   = is_st;
            dmem_addr = {ea_q[XLEN-1:2], 2'b00};
            if (is_st) begin
               dmem_be    = st_be;
               dmem_wdata = st_wdata;
            end
            if (dmem_ready) begin
               retire  = is_st;
               state_n = is_st ? S_FETCH : S_WB;
            end
         end
         S_WB: begin
            rf_we    = (rd != 5'd0);
            rf_waddr = rd;
            rf_wdata = res_q;
            retire   = 1'b1;
            state_n  = S_FETCH;
         end
         S_TRAP: begin
            trap    = 1'b1;
            state_n = S_FETCH;
         end
         default: state_n = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_PC;
         ir_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         res_q <= '0;
         npc_q <= '0;
         ea_q  <= '0;
      end else begin
         case (state_q)
            S_FETCH: if (imem_ready) ir_q <= imem_rdata;
            S_DECODE: begin
               a_q <= rf_rdata1;
               b_q <= rf_rdata2;
            end
            S_EXEC: begin
               ea_q  <= ea_sum;
               npc_q <= is_jal ? pc_imm : (is_jalr ? jalr_tgt : pc_4);
               if (is_lui)                 res_q <= imm;
               else if (is_auipc)          res_q <= pc_imm;
               else if (is_jal || is_jalr) res_q <= pc_4;
               else                        res_q <= alu_result;
               if (is_br && !(br_taken && pc_imm[1]))
                  pc_q <= br_taken ? pc_imm : pc_4;
            end
            S_MEM: begin
               if (dmem_ready) begin
                  if (is_st) pc_q  <= pc_4;
                  else       res_q <= ld_val;
               end
            end
            S_WB:    pc_q <= npc_q;
            S_TRAP:  pc_q <= TRAP_PC;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rv_multicycle_control.sv
// Directed bench for rv_multicycle_control with behavioural memories, register
// file and ALU around the controller.
module tb_rv_multicycle_control;

   logic        clk, rst_n;
   logic        imem_req, imem_ready;
   logic [31:0] imem_addr, imem_rdata;
   logic        dmem_req, dmem_we, dmem_ready;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
   logic [31:0] rf_rdata1, rf_rdata2, rf_wdata;
   logic        rf_we;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [3:0]  alu_op;
   logic [31:0] pc;
   logic        trap, retire;

   rv_multicycle_control dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
      .pc(pc), .trap(trap), .retire(retire)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] imem [0:255];
   logic [31:0] dmem [0:1023];
   logic [31:0] rf   [0:31];
   int imem_wait, dmem_wait, icnt, dcnt;
   int nstore, ndreq, nrfw;
   logic        pre_we, pre_dwe;
   logic [4:0]  pre_addr;
   logic [9:0]  pre_daddr;
   logic [31:0] pre_data;

   assign imem_rdata = imem[imem_addr[9:2]];
   assign imem_ready = imem_req && (icnt == imem_wait);
   assign dmem_rdata = dmem[dmem_addr[11:2]];
   assign dmem_ready = dmem_req && (dcnt == dmem_wait);
   assign rf_rdata1  = (rf_raddr1 == 5'd0) ? 32'h0 : rf[rf_raddr1];
   assign rf_rdata2  = (rf_raddr2 == 5'd0) ? 32'h0 : rf[rf_raddr2];

   always_comb begin
      case (alu_op)
         4'b0000: alu_result = alu_a + alu_b;
         4'b0001: alu_result = alu_a - alu_b;
         4'b0010: alu_result = alu_a & alu_b;
         4'b0011: alu_result = alu_a | alu_b;
         4'b0100: alu_result = alu_a ^ alu_b;
         4'b0101: alu_result = alu_a << alu_b[4:0];
         4'b0110: alu_result = alu_a >> alu_b[4:0];
         4'b0111: alu_result = $signed(alu_a) >>> alu_b[4:0];
         4'b1000: alu_result = {31'b0, alu_a < alu_b};
         4'b1001: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
         default: alu_result = 32'h0;
      endcase
   end

   initial begin
      icnt = 0; dcnt = 0; nstore = 0; ndreq = 0; nrfw = 0;
   end

   always @(posedge clk) begin
      if (imem_req && !imem_ready) icnt <= icnt + 1;
      else                         icnt <= 0;
      if (dmem_req && !dmem_ready) dcnt <= dcnt + 1;
      else                         dcnt <= 0;
      if (dmem_req) ndreq <= ndreq + 1;
      if (pre_dwe) dmem[pre_daddr] <= pre_data;
      if (dmem_req && dmem_we && dmem_ready) begin
         for (int i = 0; i < 4; i++)
            if (dmem_be[i]) dmem[dmem_addr[11:2]][8*i +: 8] <= dmem_wdata[8*i +: 8];
         nstore <= nstore + 1;
      end
      if (pre_we) rf[pre_addr] <= pre_data;
      if (rf_we) begin
         rf[rf_waddr] <= rf_wdata;
         nrfw <= nrfw + 1;
      end
   end

   int nvec, nerr, cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
      pre_addr = a; pre_data = d; pre_we = 1'b1;
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   task automatic set_mem(input logic [31:0] addr, input logic [31:0] d);
      pre_daddr = addr[11:2]; pre_data = d; pre_dwe = 1'b1;
      @(posedge clk); #1;
      pre_dwe = 1'b0;
   endtask

   task automatic enter_reset();
      @(negedge clk); #2;
      rst_n = 1'b0;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 1;
   endtask

   task automatic wait_cyc(input int k);
      while (cyc < k) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   int snap_st, snap_dr, snap_rw;

   initial begin
      nvec = 0; nerr = 0; cyc = 0;
      rst_n = 1'b0; pre_we = 1'b0; pre_dwe = 1'b0;
      pre_addr = '0; pre_daddr = '0; pre_data = '0;
      imem_wait = 0; dmem_wait = 0;
      for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_pc", pc, 32'h0);
      chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
      chk("rst_imem_addr", imem_addr, 32'h0);
      chk("rst_dmem_req", {31'b0, dmem_req}, 32'h0);
      chk("rst_dmem_addr", dmem_addr, 32'h0);
      chk("rst_rf_we", {31'b0, rf_we}, 32'h0);
      chk("rst_trap", {31'b0, trap}, 32'h0);
      chk("rst_retire", {31'b0, retire}, 32'h0);

      // SW x2,0(x3) stalled in MEM, then reset mid-handshake
      imem[0] = 32'h0021_A023;
      set_reg(5'd3, 32'h0000_1000);
      set_reg(5'd2, 32'hDEAD_BEEF);
      set_mem(32'h1000, 32'h1111_1111);
      dmem_wait = 50;
      release_reset();
      wait_cyc(6);
      chk("sw_stall_req", {31'b0, dmem_req}, 32'h1);
      chk("sw_stall_we", {31'b0, dmem_we}, 32'h1);
      chk("sw_stall_addr", dmem_addr, 32'h0000_1000);
      chk("sw_stall_be", {28'b0, dmem_be}, 32'hF);
      chk("sw_stall_wdata", dmem_wdata, 32'hDEAD_BEEF);
      snap_st = nstore;
      #2 rst_n = 1'b0;
      #1;
      chk("abort_req_async", {31'b0, dmem_req}, 32'h0);
      chk("abort_pc", pc, 32'h0);
      repeat (3) @(negedge clk);
      chk("abort_no_store", 32'(nstore - snap_st), 32'h0);
      chk("abort_mem_kept", dmem[0], 32'h1111_1111);

      // ADDI x1,x0,-5 ; SRAI x2,x1,1
      imem[0] = 32'hFFB0_0093;
      imem[1] = 32'h4010_D113;
      dmem_wait = 0;
      release_reset();
      chk("post_abort_pc", pc, 32'h0);
      wait_cyc(3);
      chk("addi_c3_retire", {31'b0, retire}, 32'h0);
      wait_cyc(4);
      chk("addi_retire", {31'b0, retire}, 32'h1);
      chk("addi_we", {31'b0, rf_we}, 32'h1);
      chk("addi_waddr", {27'b0, rf_waddr}, 32'd1);
      chk("addi_wdata", rf_wdata, 32'hFFFF_FFFB);
      wait_cyc(7);
      chk("srai_c7_retire", {31'b0, retire}, 32'h0);
      wait_cyc(8);
      chk("srai_retire", {31'b0, retire}, 32'h1);
      chk("srai_waddr", {27'b0, rf_waddr}, 32'd2);
      chk("srai_wdata", rf_wdata, 32'hFFFF_FFFD);
      wait_cyc(9);
      chk("srai_pc", pc, 32'h0000_0008);

      // SB x2,3(x3) with three dmem wait states
      enter_reset();
      imem[0] = 32'h0021_81A3;
      set_reg(5'd2, 32'h0000_00A5);
      set_reg(5'd3, 32'h0000_1000);
      set_mem(32'h1000, 32'h0);
      dmem_wait = 3;
      release_reset();
      wait_cyc(3);
      chk("sb_c3_req", {31'b0, dmem_req}, 32'h0);
      wait_cyc(4);
      chk("sb_req", {31'b0, dmem_req}, 32'h1);
      chk("sb_we", {31'b0, dmem_we}, 32'h1);
      chk("sb_addr", dmem_addr, 32'h0000_1000);
      chk("sb_be", {28'b0, dmem_be}, 32'h8);
      chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
      chk("sb_c4_ready", {31'b0, dmem_ready}, 32'h0);
      wait_cyc(6);
      chk("sb_c6_req", {31'b0, dmem_req}, 32'h1);
      chk("sb_c6_retire", {31'b0, retire}, 32'h0);
      chk("sb_c6_addr", dmem_addr, 32'h0000_1000);
      wait_cyc(7);
      chk("sb_c7_retire", {31'b0, retire}, 32'h1);
      wait_cyc(8);
      chk("sb_c8_req", {31'b0, dmem_req}, 32'h0);
      chk("sb_pc", pc, 32'h0000_0004);
      chk("sb_mem", dmem[0], 32'hA500_0000);

      // LB x4,1(x3) ; LBU x5,1(x3) from 0x0000_8000
      enter_reset();
      imem[0] = 32'h0011_8203;
      imem[1] = 32'h0011_C283;
      set_reg(5'd3, 32'h0000_1000);
      set_mem(32'h1000, 32'h0000_8000);
      dmem_wait = 0;
      release_reset();
      wait_cyc(4);
      chk("lb_req", {31'b0, dmem_req}, 32'h1);
      chk("lb_we", {31'b0, dmem_we}, 32'h0);
      chk("lb_addr", dmem_addr, 32'h0000_1000);
      wait_cyc(5);
      chk("lb_retire", {31'b0, retire}, 32'h1);
      chk("lb_waddr", {27'b0, rf_waddr}, 32'd4);
      chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
      wait_cyc(10);
      chk("lbu_retire", {31'b0, retire}, 32'h1);
      chk("lbu_waddr", {27'b0, rf_waddr}, 32'd5);
      chk("lbu_wdata", rf_wdata, 32'h0000_0080);

      // JAL x0,+0x40 ; BLTU x6,x7,-8 at 0x40
      enter_reset();
      imem[0]  = 32'h0400_006F;
      imem[16] = 32'hFE73_6CE3;
      set_reg(5'd6, 32'h0000_0001);
      set_reg(5'd7, 32'hFFFF_FFFF);
      release_reset();
      wait_cyc(4);
      chk("jal_retire", {31'b0, retire}, 32'h1);
      chk("jal_x0_no_we", {31'b0, rf_we}, 32'h0);
      wait_cyc(5);
      chk("jal_pc", pc, 32'h0000_0040);
      wait_cyc(7);
      chk("bltu_retire", {31'b0, retire}, 32'h1);
      chk("bltu_trap", {31'b0, trap}, 32'h0);
      wait_cyc(8);
      chk("bltu_pc", pc, 32'h0000_0038);
      chk("bltu_imem_addr", imem_addr, 32'h0000_0038);

      // LW x8,2(x3) misaligned, then illegal opcode 7F at TRAP_PC
      enter_reset();
      imem[0]  = 32'h0021_A403;
      imem[64] = 32'h0000_007F;
      set_reg(5'd3, 32'h0000_1000);
      snap_dr = ndreq;
      snap_rw = nrfw;
      release_reset();
      wait_cyc(3);
      chk("lw_c3_trap", {31'b0, trap}, 32'h0);
      wait_cyc(4);
      chk("lw_trap", {31'b0, trap}, 32'h1);
      chk("lw_trap_retire", {31'b0, retire}, 32'h0);
      wait_cyc(5);
      chk("lw_trap_pc", pc, 32'h0000_0100);
      chk("lw_no_dreq", 32'(ndreq - snap_dr), 32'h0);
      wait_cyc(7);
      chk("ill_trap", {31'b0, trap}, 32'h1);
      chk("ill_retire", {31'b0, retire}, 32'h0);
      wait_cyc(8);
      chk("ill_pc", pc, 32'h0000_0100);
      chk("trap_no_rf_write", 32'(nrfw - snap_rw), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/rv_multicycle_control.md
Name: rv_multicycle_control

Overview:
- Multi-cycle successor to the single-cycle RV32I control decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB with ready-handshaked instruction and data memories.
- Owns the PC, IR and operand registers, and drives the external register file and ALU.
- Adds full RV32I shifts-immediate, correct load extension, byte enables, misalignment/illegal trap, and a parametrised data width.

Parameters:
- XLEN, 32: datapath width; only 32 is legal for RV32I.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- TRAP_PC, 32'h0000_0100: PC loaded on an illegal or misaligned event.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  XLEN  fetch address (= pc)
- imem_ready  in  1  fetch complete; imem_rdata valid
- imem_rdata  in  32  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store
- dmem_be  out  XLEN/8  byte enables
- dmem_addr  out  XLEN  word-aligned address
- dmem_wdata  out  XLEN  lane-shifted store data
- dmem_ready  in  1  access complete; dmem_rdata valid for loads
- dmem_rdata  in  XLEN  load word
- rf_raddr1, rf_raddr2  out  5  register read addresses
- rf_rdata1, rf_rdata2  in  XLEN  combinational read data
- rf_we  out  1  register write strobe
- rf_waddr  out  5  write address
- rf_wdata  out  XLEN  write data
- alu_a, alu_b  out  XLEN  ALU operands
- alu_op  out  4  ALU operation code:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLTU, 1001 SLT
- alu_result  in  XLEN  combinational ALU result
- pc  out  XLEN  current PC
- trap  out  1  one-cycle pulse on an illegal or misaligned event
- retire  out  1  one-cycle pulse when an instruction completes

Behaviour:
- Reset (async, rst_n=0):
  - State = FETCH; pc = RESET_PC; IR = 0; A = B = 0.
  - All request, strobe and pulse outputs = 0.
  - Addresses and data outputs = 0.
  - Reset mid-handshake abandons the access; no rf or dmem write occurs afterwards.
- FETCH:
  - imem_req = 1 held until imem_ready.
  - On ready: IR <= imem_rdata, go to DECODE.
  - Zero-wait memory gives a 1-cycle FETCH.
- DECODE (1 cycle):
  - rf_raddr1 = IR[19:15], rf_raddr2 = IR[24:20].
  - A <= rf_rdata1, B <= rf_rdata2.
  - Immediate generated as I/S/B/U/J by opcode. All immediates are sign-extended, including for BLTU/BGEU.
  - Unknown opcode or funct (including SLLI/SRLI with funct7 ≠ 0000000/0100000) goes to TRAP.
- EXECUTE (1 cycle), ALU driven from A and B/imm:
  - R/I-ALU: next state WB.
  - LUI/AUIPC: next state WB; result is imm or pc+imm.
  - JAL/JALR: link = pc+4.
    - JALR target = (A+imm) & ~1.
    - A target with bit1 set goes to TRAP without writing rd.
    - Otherwise next state WB, and pc is updated in WB.
  - Branch:
    - Compare A vs B (signed for BLT/BGE, unsigned for BLTU/BGEU).
    - Taken: pc <= pc+imm. Not taken: pc <= pc+4.
    - A taken branch to a target with bit1 set goes to TRAP.
    - Otherwise retire and go to FETCH.
  - Load/store: effective address = A+imm.
    - Misaligned (LH/SH with bit0 set, LW/SW with bits[1:0] ≠ 0) goes to TRAP.
    - Otherwise go to MEM.
- MEM:
  - dmem_req held with stable addr/be/wdata until dmem_ready.
  - dmem_addr = EA & ~3.
  - SB: be = 0001 << EA[1:0]. SH: be = 0011 << EA[1:0]. SW: be = 1111.
  - Store data is replicated into the lanes.
  - Store: on ready, retire, pc += 4, go to FETCH.
  - Load: on ready, capture the lane, go to WB.
- WB (1 cycle):
  - rf_we = 1 unless rd = 0; rf_waddr = IR[11:7].
  - Write data:
    - LB/LH: sign-extended.
    - LBU/LHU: zero-extended.
    - JAL/JALR: link value.
  - pc updated; retire = 1; go to FETCH.
- TRAP (1 cycle): trap = 1, pc <= TRAP_PC, go to FETCH; no architectural writes.
- Latency with zero-wait memories:
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Each memory wait cycle adds one cycle.

Test Plan:
- Reset with rst_n=0 mid-MEM store (dmem_ready held low) -> dmem_req drops asynchronously; pc=0 after release; no write observed.
- ADDI x1,x0,-5 then SRAI x2,x1,1 (zero wait) -> x1=FFFF_FFFB at cycle 4, x2=FFFF_FFFD; retire pulses 4 cycles apart.
- SB x2 to EA=0x1003 with data2=0x0000_00A5 -> dmem_addr=0x1000, be=1000, wdata[31:24]=A5; 3 wait states stretch MEM to 4 cycles.
- LB/LBU from a word 0x0000_8000 at EA offset 1 -> LB gives FFFF_FF80, LBU gives 0000_0080.
- BLTU with A=1, B=FFFF_FFFF and imm=-8 at pc=0x40 -> pc=0x38 after 3 cycles.
- LW at EA=0x1002 -> trap pulse, pc=0x100, no dmem_req; opcode 7'h7F -> trap.
